// File: rtl/melody_sequencer_if.sv
// Player-side bundle for melody_sequencer: the button inputs and the note/gate/status outputs.
// The master side is the controller/bench and the slave side is the sequencer.
interface melody_sequencer_if #(
    parameter int IW = 4
);
    logic          play_btn;
    logic          stop_btn;
    logic [2:0]    note_out;
    logic          gate;
    logic [IW-1:0] step;
    logic          busy;
    logic          song_end;

    modport master (
        output play_btn, stop_btn,
        input  note_out, gate, step, busy, song_end
    );

    modport slave (
        input  play_btn, stop_btn,
        output note_out, gate, step, busy, song_end
    );
endinterface

// File: rtl/melody_sequencer.sv
// Autonomous tune player that steps a fixed song ROM and drives the divider note select and gate.
// Optional macro LOOP_EN: when defined, the song restarts from step 0 after each end pulse.
module melody_sequencer #(
    parameter int CLK_HZ     = 50_000_000,
    parameter int TICK_HZ    = 100,
    parameter int BEAT_TICKS = 25,
    parameter int GAP_TICKS  = 5,
    parameter int SONG_LEN   = 16,
    localparam int IW        = $clog2(SONG_LEN)
) (
    input  logic                   clk,
    input  logic                   rst,
    melody_sequencer_if.slave      bus
);
    localparam int TICK_DIV = CLK_HZ / TICK_HZ;
    localparam int TW       = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int NW       = 5 + $clog2(BEAT_TICKS + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_NOTE,
        S_GAP,
        S_END
    } state_t;

    state_t        state_q, state_d;
    logic [IW-1:0] step_q, step_d;
    logic [2:0]    note_q, note_d;
    logic [NW-1:0] cnt_q, cnt_d;
    logic [TW-1:0] tick_q, tick_d;
    logic          play_prev_q;
    logic          play_edge;
    logic          tick;
    logic [7:0]    rom_word;
    logic [2:0]    rom_note;
    logic [4:0]    rom_dur;
    logic [NW-1:0] note_load;
    logic          gate_c, busy_c, song_end_c;

    // Song: entries 0..7 play notes 0..7 for two beats each; everything after is an end marker.
    function automatic logic [7:0] rom_at(input logic [IW-1:0] idx);
        logic [7:0] w;
        w = '0;
        if (32'(idx) < 32'd8) begin
            w = {3'(idx), 5'd2};
        end
        return w;
    endfunction

    assign play_edge = bus.play_btn & ~play_prev_q;
    assign tick      = (tick_q == TW'(TICK_DIV - 1));
    assign rom_word  = rom_at(step_q);
    assign rom_note  = rom_word[7:5];
    assign rom_dur   = rom_word[4:0];
    assign note_load = NW'(rom_dur) * NW'(BEAT_TICKS) - NW'(GAP_TICKS);

    always_comb begin
        state_d    = state_q;
        step_d     = step_q;
        note_d     = note_q;
        cnt_d      = cnt_q;
        gate_c     = 1'b0;
        busy_c     = (state_q != S_IDLE);
        song_end_c = 1'b0;

        case (state_q)
            S_IDLE: begin
                step_d = '0;
                if (play_edge && !bus.stop_btn) begin
                    state_d = S_LOAD;
                end
            end
            S_LOAD: begin
                if (rom_dur == 5'd0) begin
                    state_d = S_END;
                end else begin
                    note_d  = rom_note;
                    cnt_d   = note_load;
                    state_d = S_NOTE;
                end
            end
            S_NOTE: begin
                gate_c = 1'b1;
                if (cnt_q == '0) begin
                    cnt_d   = NW'(GAP_TICKS);
                    state_d = S_GAP;
                end else if (tick) begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            S_GAP: begin
                if (cnt_q == '0) begin
                    if (step_q == IW'(SONG_LEN - 1)) begin
                        state_d = S_END;
                    end else begin
                        step_d  = step_q + 1'b1;
                        state_d = S_LOAD;
                    end
                end else if (tick) begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            S_END: begin
                song_end_c = 1'b1;
                step_d     = '0;
`ifdef LOOP_EN
                // An empty song must not spin between LOAD and END forever.
                if (rom_at('0) [4:0] != 5'd0) begin
                    state_d = S_LOAD;
                end else begin
                    state_d = S_IDLE;
                end
`else
                state_d = S_IDLE;
`endif
            end
            default: begin
                state_d = S_IDLE;
                step_d  = '0;
            end
        endcase

        // Stop overrides whatever the active state decided, and never produces an end pulse.
        if (state_q != S_IDLE && bus.stop_btn) begin
            state_d    = S_IDLE;
            step_d     = '0;
            note_d     = '0;
            cnt_d      = '0;
            song_end_c = 1'b0;
        end

        if (state_d == S_LOAD) begin
            tick_d = '0;
        end else if (tick) begin
            tick_d = '0;
        end else begin
            tick_d = tick_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            step_q      <= '0;
            note_q      <= '0;
            cnt_q       <= '0;
            tick_q      <= '0;
            play_prev_q <= 1'b1;
        end else begin
            step_q      <= step_d;
            note_q      <= note_d;
            cnt_q       <= cnt_d;
            tick_q      <= tick_d;
            play_prev_q <= bus.play_btn;
        end
    end

    assign bus.note_out = note_q;
    assign bus.step     = step_q;
    assign bus.gate     = gate_c;
    assign bus.busy     = busy_c;
    assign bus.song_end = song_end_c;
endmodule

// File: tb/tb_melody_sequencer.sv
// Directed bench for melody_sequencer at 10 clocks per tick, 4 ticks per beat, 1 gap tick.
module tb_melody_sequencer;
    localparam int IW = 4;

    typedef struct {
        logic play;
        logic stop;
        logic exp_gate;
        logic exp_busy;
        int   exp_step;
        int   exp_note;
        logic exp_end;
    } vec_t;

    logic clk = 1'b0;
    logic rst;
    int   checks   = 0;
    int   errors   = 0;
    int   se_count = 0;
    int   n;
    int   se_base;
    vec_t vecs [9];

    melody_sequencer_if #(.IW(IW)) bus ();

    melody_sequencer #(
        .CLK_HZ    (1000),
        .TICK_HZ   (100),
        .BEAT_TICKS(4),
        .GAP_TICKS (1),
        .SONG_LEN  (16)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        if (bus.song_end) se_count++;
    endtask

    task automatic wait_gate(input logic lvl, input int budget, output int cycles);
        cycles = 0;
        while (bus.gate !== lvl && cycles < budget) begin
            step();
            cycles++;
        end
        if (bus.gate !== lvl) begin
            checks++;
            errors++;
            $display("FAIL wait_gate: gate still %0b after %0d cycles, expected %0b", bus.gate, cycles, lvl);
        end
    endtask

    task automatic wait_end(input int budget, output int cycles);
        cycles = 0;
        while (bus.song_end !== 1'b1 && cycles < budget) begin
            step();
            cycles++;
        end
        if (bus.song_end !== 1'b1) begin
            checks++;
            errors++;
            $display("FAIL wait_end: no song_end after %0d cycles, expected a pulse", cycles);
        end
    endtask

    initial begin
        //          play  stop  gate  busy  step note end
        vecs[0] = '{1'b1, 1'b0, 1'b0, 1'b0, 0, 0, 1'b0};  // held through reset: no start
        vecs[1] = '{1'b1, 1'b0, 1'b0, 1'b0, 0, 0, 1'b0};
        vecs[2] = '{1'b0, 1'b0, 1'b0, 1'b0, 0, 0, 1'b0};
        vecs[3] = '{1'b1, 1'b1, 1'b0, 1'b0, 0, 0, 1'b0};  // play edge with stop: stop wins
        vecs[4] = '{1'b0, 1'b0, 1'b0, 1'b0, 0, 0, 1'b0};
        vecs[5] = '{1'b1, 1'b0, 1'b0, 1'b1, 0, 0, 1'b0};  // LOAD
        vecs[6] = '{1'b1, 1'b0, 1'b1, 1'b1, 0, 0, 1'b0};  // NOTE 0
        vecs[7] = '{1'b0, 1'b0, 1'b1, 1'b1, 0, 0, 1'b0};
        vecs[8] = '{1'b1, 1'b0, 1'b1, 1'b1, 0, 0, 1'b0};  // edge while busy ignored

        rst          = 1'b1;
        bus.play_btn = 1'b1;
        bus.stop_btn = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_gate", int'(bus.gate), 0);
        check("reset_busy", int'(bus.busy), 0);
        check("reset_step", int'(bus.step), 0);
        check("reset_note", int'(bus.note_out), 0);
        check("reset_song_end", int'(bus.song_end), 0);
        rst = 1'b0;

        for (int i = 0; i < 9; i++) begin
            bus.play_btn = vecs[i].play;
            bus.stop_btn = vecs[i].stop;
            step();
            check($sformatf("vec%0d_gate", i), int'(bus.gate), int'(vecs[i].exp_gate));
            check($sformatf("vec%0d_busy", i), int'(bus.busy), int'(vecs[i].exp_busy));
            check($sformatf("vec%0d_step", i), int'(bus.step), vecs[i].exp_step);
            check($sformatf("vec%0d_note", i), int'(bus.note_out), vecs[i].exp_note);
            check($sformatf("vec%0d_song_end", i), int'(bus.song_end), int'(vecs[i].exp_end));
        end
        bus.play_btn = 1'b0;

        // Full song: 70-clock notes, 10-clock gap plus one LOAD clock between notes.
        for (int k = 0; k < 8; k++) begin
            wait_gate(1'b0, 200, n);
            check($sformatf("note%0d_len", k), n, (k == 0) ? 68 : 70);
            check($sformatf("gap%0d_note_held", k), int'(bus.note_out), k);
            check($sformatf("gap%0d_busy", k), int'(bus.busy), 1);
            if (k < 7) begin
                wait_gate(1'b1, 50, n);
                check($sformatf("gap%0d_len", k), n, 11);
                check($sformatf("note%0d_code", k + 1), int'(bus.note_out), k + 1);
                check($sformatf("note%0d_step", k + 1), int'(bus.step), k + 1);
            end
        end
        wait_end(50, n);
        check("end_latency", n, 11);
        check("end_step", int'(bus.step), 8);
        check("end_gate", int'(bus.gate), 0);
        step();
        check("end_pulse_once", se_count, 1);
        check("after_end_song_end", int'(bus.song_end), 0);
        check("after_end_step", int'(bus.step), 0);
`ifdef LOOP_EN
        check("loop_busy", int'(bus.busy), 1);
        step();
        check("loop_gate", int'(bus.gate), 1);
        check("loop_note", int'(bus.note_out), 0);
        bus.stop_btn = 1'b1;
        step();
        bus.stop_btn = 1'b0;
        check("loop_stop_busy", int'(bus.busy), 0);
`else
        check("after_end_busy", int'(bus.busy), 0);
        check("after_end_note_kept", int'(bus.note_out), 7);
`endif

        // Stop in the middle of note 3, after an ignored play edge.
        bus.play_btn = 1'b1;
        step();
        check("p2_load_busy", int'(bus.busy), 1);
        step();
        bus.play_btn = 1'b0;
        check("p2_gate", int'(bus.gate), 1);
        for (int k = 0; k < 3; k++) begin
            wait_gate(1'b0, 200, n);
            wait_gate(1'b1, 50, n);
        end
        check("p2_note3_code", int'(bus.note_out), 3);
        repeat (5) step();
        bus.play_btn = 1'b1;
        step();
        bus.play_btn = 1'b0;
        step();
        check("busy_edge_step", int'(bus.step), 3);
        check("busy_edge_gate", int'(bus.gate), 1);
        se_base      = se_count;
        bus.stop_btn = 1'b1;
        step();
        check("stop_gate", int'(bus.gate), 0);
        check("stop_busy", int'(bus.busy), 0);
        check("stop_step", int'(bus.step), 0);
        check("stop_note", int'(bus.note_out), 0);
        check("stop_song_end", int'(bus.song_end), 0);
        bus.stop_btn = 1'b0;
        step();
        check("stop_no_pulse", se_count - se_base, 0);
        check("stop_stays_idle", int'(bus.busy), 0);

        // Asynchronous reset in the middle of the step-1 gap.
        bus.play_btn = 1'b1;
        step();
        step();
        bus.play_btn = 1'b0;
        wait_gate(1'b0, 200, n);
        wait_gate(1'b1, 50, n);
        wait_gate(1'b0, 200, n);
        repeat (4) step();
        check("pre_rst_note", int'(bus.note_out), 1);
        check("pre_rst_step", int'(bus.step), 1);
        #2;
        rst          = 1'b1;
        bus.play_btn = 1'b1;
        #1;
        check("arst_gate", int'(bus.gate), 0);
        check("arst_busy", int'(bus.busy), 0);
        check("arst_step", int'(bus.step), 0);
        check("arst_note", int'(bus.note_out), 0);
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (3) step();
        check("arst_held_play_idle", int'(bus.busy), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
